// File: rtl/block_store.sv
// Grid of multi-hit blocks: per-row presence to the painter, hit/load/fill updates, live block count.
// Latency: line_out is combinational from registered storage; pulses and count update one cycle after the edge.
// Backpressure: none; hit/load/fill_start are ignored while busy is high.
module block_store #(
    parameter int NUM_COLS = 13,
    parameter int NUM_ROWS = 16,
    parameter int HIT_BITS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       frame_start,
    input  logic                                       next_line,
    output logic [NUM_COLS-1:0]                        line_out,
    input  logic                                       hit_valid,
    input  logic [$clog2(NUM_COLS)-1:0]                hit_col,
    input  logic                                       load_valid,
    input  logic [NUM_COLS*HIT_BITS-1:0]               load_data,
    input  logic                                       fill_start,
    input  logic [HIT_BITS-1:0]                        fill_strength,
    output logic                                       busy,
    output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0]     blocks_left,
    output logic                                       hit_destroyed,
    output logic                                       cleared
);

    localparam int COL_W = $clog2(NUM_COLS);
    localparam int PTR_W = $clog2(NUM_ROWS);
    localparam int BL_W  = $clog2(NUM_ROWS*NUM_COLS+1);
    localparam int ROW_W = NUM_COLS*HIT_BITS;
    localparam int TOTAL = NUM_ROWS*NUM_COLS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [ROW_W-1:0]    grid [NUM_ROWS];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    fill_idx;
    logic [0:0]          state;
    logic [HIT_BITS-1:0] fill_str;
    logic [BL_W-1:0]     blocks_left_q;

    logic [ROW_W-1:0]    cur_row;
    logic                col_ok;
    logic [COL_W-1:0]    hit_idx;
    logic [HIT_BITS-1:0] hit_cell;
    logic                idle;
    logic                do_load;
    logic                do_hit;
    logic                hit_kill;
    logic                fill_last;
    logic                wr_en;
    logic [PTR_W-1:0]    wr_row;
    logic [ROW_W-1:0]    wr_data;
    logic [BL_W-1:0]     bl_next;

    function automatic logic [NUM_COLS-1:0] presence(input logic [ROW_W-1:0] row);
        logic [NUM_COLS-1:0] res;
        res = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            res[c] = |row[c*HIT_BITS +: HIT_BITS];
        end
        return res;
    endfunction

    function automatic logic [BL_W-1:0] popcnt(input logic [NUM_COLS-1:0] bits);
        logic [BL_W-1:0] res;
        res = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            res = res + BL_W'(bits[c]);
        end
        return res;
    endfunction

    always_comb begin
        cur_row   = grid[ptr];
        line_out  = presence(cur_row);
        col_ok    = (32'(hit_col) < 32'(NUM_COLS));
        hit_idx   = col_ok ? hit_col : '0;
        hit_cell  = cur_row[hit_idx*HIT_BITS +: HIT_BITS];
        idle      = (state == ST_IDLE);
        do_load   = idle && load_valid;
        // load wins over a coincident hit
        do_hit    = idle && hit_valid && !load_valid && col_ok && (hit_cell != '0);
        hit_kill  = do_hit && (hit_cell == HIT_BITS'(1));
        fill_last = (state == ST_FILL) && (fill_idx == PTR_W'(NUM_ROWS-1));
    end

    // Single write port: fill, load or hit, all against the pre-advance pointer.
    always_comb begin
        wr_en   = 1'b0;
        wr_row  = ptr;
        wr_data = cur_row;
        if (state == ST_FILL) begin
            wr_en   = 1'b1;
            wr_row  = fill_idx;
            wr_data = {NUM_COLS{fill_str}};
        end else if (do_load) begin
            wr_en   = 1'b1;
            wr_data = load_data;
        end else if (do_hit) begin
            wr_en   = 1'b1;
            wr_data[hit_idx*HIT_BITS +: HIT_BITS] = hit_cell - HIT_BITS'(1);
        end
    end

    always_comb begin
        bl_next = blocks_left_q;
        if (fill_last) begin
            bl_next = (fill_str != '0) ? BL_W'(TOTAL) : '0;
        end else if (do_load) begin
            bl_next = blocks_left_q - popcnt(line_out) + popcnt(presence(load_data));
        end else if (hit_kill) begin
            bl_next = blocks_left_q - BL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                grid[r] <= '0;
            end
        end else if (wr_en) begin
            grid[wr_row] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (fill_last || frame_start) begin
            ptr <= '0;
        end else if (next_line) begin
            ptr <= (ptr == PTR_W'(NUM_ROWS-1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fill_idx <= '0;
            fill_str <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fill_start) begin
                        state    <= ST_FILL;
                        fill_idx <= '0;
                        fill_str <= fill_strength;
                    end
                end
                default: begin
                    fill_idx <= fill_idx + PTR_W'(1);
                    if (fill_last) begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // cleared only tracks hit/load driving the count to zero; a fill never raises it
    always_ff @(posedge clk) begin
        if (rst) begin
            blocks_left_q <= '0;
            hit_destroyed <= 1'b0;
            cleared       <= 1'b0;
        end else begin
            blocks_left_q <= bl_next;
            hit_destroyed <= hit_kill;
            cleared       <= (do_load || hit_kill) && (blocks_left_q != '0) && (bl_next == '0);
        end
    end

    assign busy        = (state == ST_FILL);
    assign blocks_left = blocks_left_q;

endmodule

// File: tb/tb_block_store.sv
// Directed bench for block_store: expected outputs queued with each stimulus step, popped after the edge.
module tb_block_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        next_line;
    logic [12:0] line_out;
    logic        hit_valid;
    logic [3:0]  hit_col;
    logic        load_valid;
    logic [25:0] load_data;
    logic        fill_start;
    logic [1:0]  fill_strength;
    logic        busy;
    logic [7:0]  blocks_left;
    logic        hit_destroyed;
    logic        cleared;

    always #5 clk = ~clk;

    block_store #(.NUM_COLS(13), .NUM_ROWS(16), .HIT_BITS(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .next_line     (next_line),
        .line_out      (line_out),
        .hit_valid     (hit_valid),
        .hit_col       (hit_col),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .fill_start    (fill_start),
        .fill_strength (fill_strength),
        .busy          (busy),
        .blocks_left   (blocks_left),
        .hit_destroyed (hit_destroyed),
        .cleared       (cleared)
    );

    typedef struct packed {
        logic [12:0] line;
        logic [7:0]  bl;
        logic        bz;
        logic        hd;
        logic        cl;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty, got no entry want one", tag);
        end else begin
            e = sb.pop_front();
            total++;
            assert (line_out === e.line) else begin
                bad++; $error("FAIL %s line_out: got %h want %h", tag, line_out, e.line);
            end
            total++;
            assert (blocks_left === e.bl) else begin
                bad++; $error("FAIL %s blocks_left: got %0d want %0d", tag, blocks_left, e.bl);
            end
            total++;
            assert (busy === e.bz) else begin
                bad++; $error("FAIL %s busy: got %b want %b", tag, busy, e.bz);
            end
            total++;
            assert (hit_destroyed === e.hd) else begin
                bad++; $error("FAIL %s hit_destroyed: got %b want %b", tag, hit_destroyed, e.hd);
            end
            total++;
            assert (cleared === e.cl) else begin
                bad++; $error("FAIL %s cleared: got %b want %b", tag, cleared, e.cl);
            end
        end
    endtask

    task automatic step(input string tag, input logic [12:0] l, input logic [7:0] b,
                        input logic bz, input logic hd, input logic cl);
        exp_t e;
        e.line = l; e.bl = b; e.bz = bz; e.hd = hd; e.cl = cl;
        sb.push_back(e);
        tick();
        compare(tag);
    endtask

    initial begin
        int   n;
        logic seen_clr;

        rst = 1'b1; frame_start = 1'b0; next_line = 1'b0; hit_valid = 1'b0; hit_col = '0;
        load_valid = 1'b0; load_data = '0; fill_start = 1'b0; fill_strength = '0;
        step("reset", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // full fill at strength 2, with a hit injected mid-fill
        fill_start = 1'b1; fill_strength = 2'd2;
        step("fill_go", 13'h0000, 8'd0, 1'b1, 1'b0, 1'b0);
        fill_start = 1'b0;
        n = 1;
        while (busy && n < 40) begin
            hit_valid = (n == 4);
            hit_col   = 4'd0;
            tick();
            if (busy) n++;
        end
        hit_valid = 1'b0;
        total++;
        assert (n == 16) else begin
            bad++; $error("FAIL fill_len: got %0d busy cycles want 16", n);
        end
        step("fill_done", 13'h1FFF, 8'd208, 1'b0, 1'b0, 1'b0);

        next_line = 1'b1;
        for (int r = 0; r < 16; r++) step("row_scan", 13'h1FFF, 8'd208, 1'b0, 1'b0, 1'b0);
        next_line = 1'b0;

        // multi-hit on row 0 col 5
        hit_valid = 1'b1; hit_col = 4'd5;
        step("hit1", 13'h1FFF, 8'd208, 1'b0, 1'b0, 1'b0);
        step("hit2", 13'h1FDF, 8'd207, 1'b0, 1'b1, 1'b0);
        hit_valid = 1'b0;
        step("hit_idle", 13'h1FDF, 8'd207, 1'b0, 1'b0, 1'b0);
        hit_valid = 1'b1;
        step("hit3_empty", 13'h1FDF, 8'd207, 1'b0, 1'b0, 1'b0);
        hit_col = 4'd13;
        step("hit_oob", 13'h1FDF, 8'd207, 1'b0, 1'b0, 1'b0);
        hit_valid = 1'b0;

        // pointer wraps back onto the modified row 0
        next_line = 1'b1;
        step("wrap_r1", 13'h1FFF, 8'd207, 1'b0, 1'b0, 1'b0);
        repeat (14) tick();
        step("wrap_r0", 13'h1FDF, 8'd207, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        step("row3", 13'h1FFF, 8'd207, 1'b0, 1'b0, 1'b0);
        next_line = 1'b0;

        // load beats coincident hit
        load_valid = 1'b1; load_data = 26'h1111111; hit_valid = 1'b1; hit_col = 4'd0;
        step("load", 13'h1555, 8'd201, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b0;
        step("hit_after_load", 13'h1554, 8'd200, 1'b0, 1'b1, 1'b0);
        hit_valid = 1'b0;

        next_line = 1'b1;
        repeat (3) tick();
        step("row7", 13'h1FFF, 8'd200, 1'b0, 1'b0, 1'b0);
        frame_start = 1'b1;
        step("fs_nl", 13'h1FDF, 8'd200, 1'b0, 1'b0, 1'b0);
        frame_start = 1'b0; next_line = 1'b0;

        // hit with next_line lands on the pre-advance row
        hit_valid = 1'b1; hit_col = 4'd6;
        step("hit6a", 13'h1FDF, 8'd200, 1'b0, 1'b0, 1'b0);
        next_line = 1'b1;
        step("hit6b_adv", 13'h1FFF, 8'd199, 1'b0, 1'b1, 1'b0);
        hit_valid = 1'b0; next_line = 1'b0; frame_start = 1'b1;
        step("row0_back", 13'h1F9F, 8'd199, 1'b0, 1'b0, 1'b0);
        frame_start = 1'b0;

        // strength-0 fill empties the grid without a cleared pulse
        fill_start = 1'b1; fill_strength = 2'd0;
        step("fill0_go", 13'h1F9F, 8'd199, 1'b1, 1'b0, 1'b0);
        fill_start = 1'b0;
        n = 1;
        seen_clr = 1'b0;
        while (busy && n < 40) begin
            tick();
            if (cleared) seen_clr = 1'b1;
            if (busy) n++;
        end
        total++;
        assert (n == 16) else begin
            bad++; $error("FAIL fill0_len: got %0d busy cycles want 16", n);
        end
        total++;
        assert (seen_clr === 1'b0) else begin
            bad++; $error("FAIL fill0_cleared: got %b want 0", seen_clr);
        end
        step("fill0_done", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);

        // single last block at row 15 col 12
        next_line = 1'b1;
        repeat (14) tick();
        step("row15", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
        next_line = 1'b0;
        load_valid = 1'b1; load_data = 26'h1000000;
        step("load_one", 13'h1000, 8'd1, 1'b0, 1'b0, 1'b0);
        load_valid = 1'b0; hit_valid = 1'b1; hit_col = 4'd12;
        step("last_hit", 13'h0000, 8'd0, 1'b0, 1'b1, 1'b1);
        hit_valid = 1'b0;
        step("pulse_end", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a fill
        fill_start = 1'b1; fill_strength = 2'd3;
        step("fill3_go", 13'h0000, 8'd0, 1'b1, 1'b0, 1'b0);
        fill_start = 1'b0;
        repeat (7) tick();
        step("fill_mid", 13'h0000, 8'd0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step("rst_mid", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step("after_rst", 13'h0000, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_store.md
Name: block_store

Overview:
Parametrised successor to the single-bit block-line state store. It holds a NUM_ROWS x NUM_COLS grid of multi-hit blocks, each with a HIT_BITS-wide strength, and presents the presence bits of the current row to the blocks painter. It accepts collision hits from the painter, whole-row loads from the SPI controller, and a bulk refill. It also maintains a live remaining-blocks count and emits a level-cleared pulse for game logic.

Parameters:
NUM_COLS, 13, blocks per row
NUM_ROWS, 16, rows in grid (>=2)
HIT_BITS, 2, strength bits per block; 0 = absent, max 2^HIT_BITS-1

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
frame_start  input  1  realign row pointer to row 0
next_line  input  1  advance row pointer
line_out  output  NUM_COLS  presence bits of current row (bit c = strength[c]!=0)
hit_valid  input  1  decrement one block in current row
hit_col  input  $clog2(NUM_COLS)  column of hit
load_valid  input  1  overwrite current row
load_data  input  NUM_COLS*HIT_BITS  new row strengths, column c at [c*HIT_BITS +: HIT_BITS]
fill_start  input  1  begin bulk fill of all rows
fill_strength  input  HIT_BITS  strength written to every cell during fill
busy  output  1  fill in progress
blocks_left  output  $clog2(NUM_ROWS*NUM_COLS+1)  count of cells with nonzero strength
hit_destroyed  output  1  pulse: a hit reduced a cell to 0
cleared  output  1  pulse: blocks_left went nonzero -> 0

Behaviour:
- Reset (rst=1 at clk edge): all cells 0, row pointer 0, FSM IDLE, busy=0, blocks_left=0, hit_destroyed=0, cleared=0. Reset mid-fill aborts the fill immediately.
- Storage is registered. line_out is a combinational mux of the registered row at the pointer, so it reflects a pointer change or write on the cycle after the triggering edge.
- Pointer rules:
  - frame_start -> 0.
  - Otherwise next_line -> pointer+1, wrapping NUM_ROWS-1 -> 0.
  - frame_start has priority when both are asserted.
- FSM states: IDLE and FILL.
  - IDLE -> FILL on fill_start. Latch fill_strength, set fill index 0, busy=1 from the next cycle.
  - FILL writes one row per cycle (index 0..NUM_ROWS-1). After the last row, return to IDLE, pointer=0, busy=0.
  - Fill takes exactly NUM_ROWS cycles.
  - In FILL: hit_valid, load_valid, fill_start are ignored; frame_start/next_line still move the pointer, but the pointer is forced to 0 on exit.
- Hit (IDLE):
  - Cell (pointer, hit_col) strength decremented, saturating at 0.
  - If the cell goes 1 -> 0: blocks_left decrements and hit_destroyed pulses on the next cycle.
  - Hit on a 0 cell, or hit_col >= NUM_COLS: no change, no pulse.
- Load (IDLE): row at pointer := load_data. blocks_left := blocks_left - popcount(old nonzero) + popcount(new nonzero).
- Simultaneous events:
  - load_valid and hit_valid in the same cycle: load wins, hit dropped.
  - A write together with next_line/frame_start targets the pre-advance row.
- Fill completion: blocks_left = NUM_ROWS*NUM_COLS if the latched strength is nonzero, else 0. blocks_left is updated once on the final fill cycle.
- cleared: single-cycle pulse, registered, same timing as hit_destroyed. It fires whenever blocks_left transitions nonzero -> 0 by hit or load. It never fires from reset, and never from a fill with strength 0.
- blocks_left never under/overflows; its width covers NUM_ROWS*NUM_COLS exactly.

Test Plan:
- Reset, then fill_start with fill_strength=2 -> busy=1 for 16 cycles; then blocks_left=208, line_out=13'h1FFF on every row visited by 16 next_line pulses, pointer wraps back to row 0 on the 17th.
- Row 0, hit_col=5 twice -> first hit: line_out unchanged, no pulse; second: line_out bit5=0, hit_destroyed pulses one cycle, blocks_left=207; third hit on col 5 -> no change.
- Pointer at row 3, load_valid with cols 0..12 = {1,0,1,0,...} (7 nonzero) on a full-strength row -> blocks_left drops by 6, line_out=13'h1555 next cycle; same cycle hit_valid col 0 -> ignored.
- Grid with one block of strength 1 at row 15 col 12: advance to row 15, hit col 12 -> blocks_left=0, hit_destroyed and cleared both pulse once.
- frame_start and next_line together at row 7 -> pointer 0; hit during FILL -> no effect, blocks_left after fill = 208.
- Assert rst at fill cycle 8 -> next cycle busy=0, blocks_left=0, line_out=0, no cleared pulse.
